// File: rtl/alien_fleet_ctrl_pkg.sv
// Shared game geometry, FSM encoding and grid helpers for the alien fleet
// controller and the VGA draw stage.
package alien_fleet_ctrl_pkg;

   localparam int NUM_ROWS    = 5;
   localparam int NUM_COLS    = 10;
   localparam int ALIEN_W     = 30;
   localparam int ALIEN_H     = 20;
   localparam int SPACE_W     = 10;
   localparam int SPACE_H     = 10;
   localparam int START_COL   = 20;
   localparam int START_ROW   = 40;
   localparam int STEP_X      = 10;
   localparam int STEP_Y      = 10;
   localparam int SCREEN_W    = 640;
   localparam int BOTTOM_ROW  = 440;
   localparam int MOVE_FRAMES = 30;

   localparam int GRID_BITS = NUM_ROWS * NUM_COLS;
   localparam int PITCH_X   = ALIEN_W + SPACE_W;
   localparam int PITCH_Y   = ALIEN_H + SPACE_H;
   localparam int ROW_IDX_W = $clog2(NUM_ROWS);
   localparam int COL_IDX_W = $clog2(NUM_COLS);
   localparam int FRAME_W   = $clog2(MOVE_FRAMES + 1);
   localparam int ROW_W     = 9;
   localparam int COL_W     = 10;
   localparam int CALC_W    = 11;

   typedef enum logic [1:0] {
      FLEET_WAIT   = 2'd0,
      FLEET_SCAN   = 2'd1,
      FLEET_DECIDE = 2'd2,
      FLEET_HALT   = 2'd3
   } fleet_state_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } march_dir_t;

   // Index of the highest-numbered (lowest on screen) row with a live alien.
   function automatic logic [ROW_IDX_W-1:0] lowestLiveRow(input logic [GRID_BITS-1:0] grid);
      logic [ROW_IDX_W-1:0] lowest;
      lowest = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (|grid[r*NUM_COLS +: NUM_COLS]) begin
            lowest = ROW_IDX_W'(r);
         end
      end
      return lowest;
   endfunction

endpackage

// File: rtl/alien_fleet_ctrl_if.sv
// Request/status bundle between the game logic (master) and the fleet
// controller (slave); also carries the formation outputs to the draw stage.
interface alien_fleet_ctrl_if;
   import alien_fleet_ctrl_pkg::*;

   logic                 FrameTick;
   logic                 Restart;
   logic                 HitValid;
   logic [ROW_W-1:0]     HitRow;
   logic [COL_W-1:0]     HitCol;
   logic                 HitAck;
   logic                 HitKill;
   logic [GRID_BITS-1:0] Aliens_Grid;
   logic [ROW_W-1:0]     AliensRow;
   logic [COL_W-1:0]     AliensCol;
   logic                 AllDead;
   logic                 ReachedBottom;

   modport master (
      output FrameTick, Restart, HitValid, HitRow, HitCol,
      input  HitAck, HitKill, Aliens_Grid, AliensRow, AliensCol, AllDead, ReachedBottom
   );

   modport slave (
      input  FrameTick, Restart, HitValid, HitRow, HitCol,
      output HitAck, HitKill, Aliens_Grid, AliensRow, AliensCol, AllDead, ReachedBottom
   );

endinterface

// File: rtl/alien_fleet_ctrl_hit_decode.sv
// Maps a screen point to the alien cell it lands in, relative to the
// formation origin; points in gaps or outside the formation are invalid.
module alien_hit_decode
   import alien_fleet_ctrl_pkg::*;
(
   input  logic [ROW_W-1:0]     i_PointRow,
   input  logic [COL_W-1:0]     i_PointCol,
   input  logic [ROW_W-1:0]     i_OriginRow,
   input  logic [COL_W-1:0]     i_OriginCol,
   output logic                 o_CellValid,
   output logic [ROW_IDX_W-1:0] o_RowIdx,
   output logic [COL_IDX_W-1:0] o_ColIdx
);

   int   w_Dx;
   int   w_Dy;
   logic w_RowHit;
   logic w_ColHit;

   // Negative offsets never satisfy a box comparison, so points above or
   // left of the origin fall out without a separate check.
   always_comb begin
      w_Dx     = int'(i_PointCol) - int'(i_OriginCol);
      w_Dy     = int'(i_PointRow) - int'(i_OriginRow);
      w_RowHit = 1'b0;
      w_ColHit = 1'b0;
      o_RowIdx = '0;
      o_ColIdx = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (w_Dx >= c*PITCH_X && w_Dx < c*PITCH_X + ALIEN_W) begin
            w_ColHit = 1'b1;
            o_ColIdx = COL_IDX_W'(c);
         end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (w_Dy >= r*PITCH_Y && w_Dy < r*PITCH_Y + ALIEN_H) begin
            w_RowHit = 1'b1;
            o_RowIdx = ROW_IDX_W'(r);
         end
      end
      o_CellValid = w_RowHit & w_ColHit;
   end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien formation owner: live grid, origin and march direction; marches every
// MOVE_FRAMES frames, drops and reverses at screen edges, and serves bullet hits.
module alien_fleet_ctrl
   import alien_fleet_ctrl_pkg::*;
(
   input  logic              i_Clk,
   input  logic              i_Reset,
   alien_fleet_ctrl_if.slave fleet
);

   fleet_state_t         r_State, w_NextState;
   logic [GRID_BITS-1:0] r_Grid;
   logic [ROW_W-1:0]     r_Row;
   logic [COL_W-1:0]     r_Col;
   march_dir_t           r_Dir;
   logic [FRAME_W-1:0]   r_FrameCount;
   logic [COL_IDX_W-1:0] r_ScanIdx, r_Left, r_Right;
   logic                 r_AnyLive;
   logic                 r_HitAck, r_HitKill, r_AllDead, r_Bottom;

   logic                 w_CellValid;
   logic [ROW_IDX_W-1:0] w_HitRowIdx;
   logic [COL_IDX_W-1:0] w_HitColIdx;
   logic [GRID_BITS-1:0] w_HitMask;
   logic                 w_Kill;
   logic                 w_ColOcc;
   logic [ROW_IDX_W-1:0] w_Lowest;
   logic [CALC_W-1:0]    w_RightReach, w_LeftReach, w_DropRow, w_BottomReach;
   logic                 w_Accept, w_StartScan, w_Move, w_Drop;
   logic                 w_SetBottom, w_SetDead, w_Reload, w_CountUp, w_CountClr;

   alien_hit_decode u_hit_decode (
      .i_PointRow  (fleet.HitRow),
      .i_PointCol  (fleet.HitCol),
      .i_OriginRow (r_Row),
      .i_OriginCol (r_Col),
      .o_CellValid (w_CellValid),
      .o_RowIdx    (w_HitRowIdx),
      .o_ColIdx    (w_HitColIdx)
   );

   always_comb begin
      w_HitMask = '0;
      w_ColOcc  = 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            if (w_CellValid && w_HitRowIdx == ROW_IDX_W'(r) && w_HitColIdx == COL_IDX_W'(c)) begin
               w_HitMask[r*NUM_COLS + c] = 1'b1;
            end
            if (r_ScanIdx == COL_IDX_W'(c) && r_Grid[r*NUM_COLS + c]) begin
               w_ColOcc = 1'b1;
            end
         end
      end
      w_Kill = |(w_HitMask & r_Grid);
   end

   assign w_Lowest      = lowestLiveRow(r_Grid);
   assign w_RightReach  = CALC_W'(r_Col) + CALC_W'(r_Right) * CALC_W'(PITCH_X) + CALC_W'(ALIEN_W + STEP_X);
   assign w_LeftReach   = CALC_W'(r_Col) + CALC_W'(r_Left) * CALC_W'(PITCH_X);
   assign w_DropRow     = CALC_W'(r_Row) + CALC_W'(STEP_Y);
   assign w_BottomReach = w_DropRow + CALC_W'(w_Lowest) * CALC_W'(PITCH_Y) + CALC_W'(ALIEN_H);

   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_State <= FLEET_WAIT;
      end else begin
         r_State <= w_NextState;
      end
   end

   always_comb begin
      w_NextState = r_State;
      w_Accept    = 1'b0;
      w_StartScan = 1'b0;
      w_Move      = 1'b0;
      w_Drop      = 1'b0;
      w_SetBottom = 1'b0;
      w_SetDead   = 1'b0;
      w_Reload    = 1'b0;
      w_CountUp   = 1'b0;
      w_CountClr  = 1'b0;
      case (r_State)
         FLEET_WAIT: begin
            w_Accept = fleet.HitValid && !r_HitAck;
            if (fleet.FrameTick) begin
               if (r_FrameCount == FRAME_W'(MOVE_FRAMES - 1)) begin
                  w_CountClr  = 1'b1;
                  w_StartScan = 1'b1;
                  w_NextState = FLEET_SCAN;
               end else begin
                  w_CountUp = 1'b1;
               end
            end
         end
         FLEET_SCAN: begin
            if (r_ScanIdx == COL_IDX_W'(NUM_COLS - 1)) begin
               w_NextState = FLEET_DECIDE;
            end
         end
         FLEET_DECIDE: begin
            w_NextState = FLEET_WAIT;
            if ((r_Dir == DIR_RIGHT) ? (w_RightReach > CALC_W'(SCREEN_W))
                                     : (w_LeftReach < CALC_W'(STEP_X))) begin
               w_Drop = 1'b1;
               if (w_BottomReach >= CALC_W'(BOTTOM_ROW)) begin
                  w_SetBottom = 1'b1;
                  w_NextState = FLEET_HALT;
               end
            end else begin
               w_Move = 1'b1;
            end
         end
         FLEET_HALT: begin
            if (fleet.Restart) begin
               w_Reload    = 1'b1;
               w_NextState = FLEET_WAIT;
            end
         end
      endcase
      // An emptied grid wins over any motion or invasion decided this cycle.
      if (r_State != FLEET_HALT && r_Grid == '0) begin
         w_NextState = FLEET_HALT;
         w_SetDead   = 1'b1;
         w_Move      = 1'b0;
         w_Drop      = 1'b0;
         w_SetBottom = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset || w_Reload) begin
         r_Grid       <= '1;
         r_Row        <= ROW_W'(START_ROW);
         r_Col        <= COL_W'(START_COL);
         r_Dir        <= DIR_RIGHT;
         r_FrameCount <= '0;
         r_ScanIdx    <= '0;
         r_Left       <= '0;
         r_Right      <= '0;
         r_AnyLive    <= 1'b0;
         r_HitAck     <= 1'b0;
         r_HitKill    <= 1'b0;
         r_AllDead    <= 1'b0;
         r_Bottom     <= 1'b0;
      end else begin
         r_HitAck  <= w_Accept;
         r_HitKill <= w_Accept && w_Kill;
         if (w_Accept) begin
            r_Grid <= r_Grid & ~w_HitMask;
         end
         if (w_CountClr) begin
            r_FrameCount <= '0;
         end else if (w_CountUp) begin
            r_FrameCount <= r_FrameCount + 1'b1;
         end
         // Columns are visited in ascending order, so the first live one is the leftmost.
         if (w_StartScan) begin
            r_ScanIdx <= '0;
            r_AnyLive <= 1'b0;
         end else if (r_State == FLEET_SCAN) begin
            r_ScanIdx <= r_ScanIdx + 1'b1;
            if (w_ColOcc) begin
               r_AnyLive <= 1'b1;
               r_Right   <= r_ScanIdx;
               if (!r_AnyLive) begin
                  r_Left <= r_ScanIdx;
               end
            end
         end
         if (w_Move) begin
            r_Col <= (r_Dir == DIR_RIGHT) ? r_Col + COL_W'(STEP_X) : r_Col - COL_W'(STEP_X);
         end
         if (w_Drop) begin
            r_Row <= ROW_W'(w_DropRow);
            r_Dir <= (r_Dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
         end
         if (w_SetBottom) begin
            r_Bottom <= 1'b1;
         end
         if (w_SetDead) begin
            r_AllDead <= 1'b1;
         end
      end
   end

   assign fleet.HitAck        = r_HitAck;
   assign fleet.HitKill       = r_HitKill;
   assign fleet.Aliens_Grid   = r_Grid;
   assign fleet.AliensRow     = r_Row;
   assign fleet.AliensCol     = r_Col;
   assign fleet.AllDead       = r_AllDead;
   assign fleet.ReachedBottom = r_Bottom;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Directed bench for alien_fleet_ctrl: reset, hits, marching to the edge,
// clearing the fleet, restart and reset during a scan.
module tb_alien_fleet_ctrl;
   import alien_fleet_ctrl_pkg::*;

   logic clk = 1'b0;
   logic resetN;
   int   vectors = 0;
   int   miscompares = 0;

   alien_fleet_ctrl_if fleet();

   alien_fleet_ctrl dut (
      .i_Clk   (clk),
      .i_Reset (resetN),
      .fleet   (fleet)
   );

   always #5 clk = ~clk;

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyHit(input string tag, input int row, input int col,
                           input logic expAck, input logic expKill);
      fleet.HitValid = 1'b1;
      fleet.HitRow   = 9'(row);
      fleet.HitCol   = 10'(col);
      stepCycles(1);
      checkOutput({tag, ".ack"}, 64'(fleet.HitAck), 64'(expAck));
      checkOutput({tag, ".kill"}, 64'(fleet.HitKill), 64'(expKill));
      fleet.HitValid = 1'b0;
      stepCycles(1);
   endtask

   task automatic pulseFrames(input int n);
      for (int i = 0; i < n; i++) begin
         fleet.FrameTick = 1'b1;
         stepCycles(1);
         fleet.FrameTick = 1'b0;
         if (i != n - 1) stepCycles(1);
      end
   endtask

   task automatic marchOnce();
      pulseFrames(30);
      stepCycles(11);
   endtask

   task automatic checkOrigin(input string tag, input int row, input int col);
      checkOutput({tag, ".row"}, 64'(fleet.AliensRow), 64'(row));
      checkOutput({tag, ".col"}, 64'(fleet.AliensCol), 64'(col));
   endtask

   initial begin
      resetN          = 1'b0;
      fleet.FrameTick = 1'b0;
      fleet.Restart   = 1'b0;
      fleet.HitValid  = 1'b0;
      fleet.HitRow    = '0;
      fleet.HitCol    = '0;
      stepCycles(1);
      checkOutput("rst.grid", 64'(fleet.Aliens_Grid), 64'h3_FFFF_FFFF_FFFF);
      checkOrigin("rst", 40, 20);
      checkOutput("rst.ack", 64'(fleet.HitAck), 64'd0);
      checkOutput("rst.kill", 64'(fleet.HitKill), 64'd0);
      checkOutput("rst.dead", 64'(fleet.AllDead), 64'd0);
      checkOutput("rst.bottom", 64'(fleet.ReachedBottom), 64'd0);
      resetN = 1'b1;

      applyHit("hit_c0", 45, 25, 1'b1, 1'b1);
      checkOutput("hit_c0.ackDrop", 64'(fleet.HitAck), 64'd0);
      checkOutput("hit_c0.grid", 64'(fleet.Aliens_Grid), 64'h3_FFFF_FFFF_FFFE);
      applyHit("hit_repeat", 45, 25, 1'b1, 1'b0);
      applyHit("hit_gap", 45, 55, 1'b1, 1'b0);
      applyHit("hit_leftOfOrigin", 45, 10, 1'b1, 1'b0);
      applyHit("hit_pastLastCol", 45, 410, 1'b1, 1'b0);
      applyHit("hit_c1LeftEdge", 45, 60, 1'b1, 1'b1);
      applyHit("hit_r4c9Corner", 179, 409, 1'b1, 1'b1);
      checkOutput("hits.grid", 64'(fleet.Aliens_Grid), 64'h1_FFFF_FFFF_FFFC);

      fleet.Restart = 1'b1;
      stepCycles(1);
      fleet.Restart = 1'b0;
      checkOutput("restartInWait.grid", 64'(fleet.Aliens_Grid), 64'h1_FFFF_FFFF_FFFC);

      resetN = 1'b0;
      stepCycles(1);
      resetN = 1'b1;
      checkOutput("rst2.grid", 64'(fleet.Aliens_Grid), 64'h3_FFFF_FFFF_FFFF);

      pulseFrames(30);
      stepCycles(10);
      checkOrigin("march1.beforeDecide", 40, 20);
      stepCycles(1);
      checkOrigin("march1", 40, 30);

      pulseFrames(30);
      fleet.HitValid = 1'b1;
      fleet.HitRow   = 9'd45;
      fleet.HitCol   = 10'd45;
      stepCycles(11);
      checkOutput("hitDuringScan.held", 64'(fleet.HitAck), 64'd0);
      checkOrigin("march2", 40, 40);
      stepCycles(1);
      checkOutput("hitDuringScan.ack", 64'(fleet.HitAck), 64'd1);
      checkOutput("hitDuringScan.kill", 64'(fleet.HitKill), 64'd1);
      fleet.HitValid = 1'b0;
      stepCycles(1);

      for (int i = 0; i < 21; i++) marchOnce();
      checkOrigin("atEdge", 40, 250);
      marchOnce();
      checkOrigin("drop", 50, 250);
      marchOnce();
      checkOrigin("marchLeft", 50, 240);
      checkOutput("marchLeft.bottom", 64'(fleet.ReachedBottom), 64'd0);

      pulseFrames(30);
      stepCycles(3);
      fleet.HitValid = 1'b1;
      fleet.HitRow   = 9'd45;
      fleet.HitCol   = 10'd25;
      resetN         = 1'b0;
      stepCycles(1);
      checkOutput("rstScan.grid", 64'(fleet.Aliens_Grid), 64'h3_FFFF_FFFF_FFFF);
      checkOrigin("rstScan", 40, 20);
      checkOutput("rstScan.ack", 64'(fleet.HitAck), 64'd0);
      resetN         = 1'b1;
      fleet.HitValid = 1'b0;

      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 10; c++) begin
            applyHit($sformatf("clear_r%0d_c%0d", r, c), 45 + r*30, 25 + c*40, 1'b1, 1'b1);
         end
      end
      checkOutput("cleared.grid", 64'(fleet.Aliens_Grid), 64'd0);
      checkOutput("cleared.dead", 64'(fleet.AllDead), 64'd1);
      checkOutput("cleared.bottom", 64'(fleet.ReachedBottom), 64'd0);

      applyHit("halt_hitIgnored", 45, 25, 1'b0, 1'b0);
      marchOnce();
      checkOrigin("halt_noMotion", 40, 20);

      fleet.Restart = 1'b1;
      stepCycles(1);
      fleet.Restart = 1'b0;
      checkOutput("restart.grid", 64'(fleet.Aliens_Grid), 64'h3_FFFF_FFFF_FFFF);
      checkOrigin("restart", 40, 20);
      checkOutput("restart.dead", 64'(fleet.AllDead), 64'd0);
      applyHit("restart_hitServed", 45, 25, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
